// File: rtl/riscv_pkg.sv
// Shared RV32I types, opcode/funct constants and immediate extraction helpers.
package riscv_pkg;

  localparam int unsigned RV_XLEN = 32;
  localparam int unsigned RV_ADDR = 5;

  typedef logic [6:0] opcode_t;
  localparam opcode_t OP_LOAD    = 7'b0000011;
  localparam opcode_t OP_REG_IMM = 7'b0010011;
  localparam opcode_t OP_STORE   = 7'b0100011;
  localparam opcode_t OP_REG_REG = 7'b0110011;
  localparam opcode_t OP_BRANCH  = 7'b1100011;

  typedef logic [2:0] funct3_t;
  localparam funct3_t F3_ADD_SUB = 3'b000;
  localparam funct3_t F3_SLL     = 3'b001;
  localparam funct3_t F3_SRL_SRA = 3'b101;

  // ADD/SRL and SUB/SRA share encodings, so these are plain constants.
  typedef logic [6:0] funct7_t;
  localparam funct7_t F7_ADD = 7'b0000000;
  localparam funct7_t F7_SRL = 7'b0000000;
  localparam funct7_t F7_SUB = 7'b0100000;
  localparam funct7_t F7_SRA = 7'b0100000;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_ILL = 3'd4
  } instr_fmt_t;

  typedef struct packed {
    logic [RV_XLEN-1:0] pc;
    opcode_t            opcode;
    instr_fmt_t         fmt;
    logic [RV_ADDR-1:0] rd;
    logic [RV_ADDR-1:0] rs1;
    logic [RV_ADDR-1:0] rs2;
    funct3_t            funct3;
    funct7_t            funct7;
    logic [RV_XLEN-1:0] imm;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               branch;
    logic               alu_src_imm;
    logic               illegal;
  } decoded_instr_t;

  function automatic logic [RV_XLEN-1:0] imm_i(input logic [31:0] instr);
    return {{(RV_XLEN-12){instr[31]}}, instr[31:20]};
  endfunction

  function automatic logic [RV_XLEN-1:0] imm_s(input logic [31:0] instr);
    return {{(RV_XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  endfunction

  function automatic logic [RV_XLEN-1:0] imm_b(input logic [31:0] instr);
    return {{(RV_XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/riscv_instr_decoder.sv
// Combinational RV32I decoder: raw instruction word to decoded_instr_t.
module riscv_instr_decoder
  import riscv_pkg::*;
(
  input  logic [31:0]         i_instr,
  input  logic [RV_XLEN-1:0]  i_pc,
  output decoded_instr_t      o_dec
);

  opcode_t w_op;
  funct3_t w_f3;
  funct7_t w_f7;
  logic    w_legal;

  assign w_op = i_instr[6:0];
  assign w_f3 = i_instr[14:12];
  assign w_f7 = i_instr[31:25];

  always_comb begin
    o_dec        = '0;
    o_dec.pc     = i_pc;
    o_dec.opcode = w_op;
    o_dec.rd     = i_instr[11:7];
    o_dec.rs1    = i_instr[19:15];
    o_dec.rs2    = i_instr[24:20];
    o_dec.funct3 = w_f3;
    w_legal      = 1'b0;
    case (w_op)
      OP_REG_REG: begin
        w_legal = (w_f7 == F7_ADD) ||
                  (w_f7 == F7_SUB && (w_f3 == F3_ADD_SUB || w_f3 == F3_SRL_SRA));
        o_dec.fmt       = FMT_R;
        o_dec.funct7    = w_f7;
        o_dec.reg_write = 1'b1;
      end
      OP_REG_IMM: begin
        w_legal = !((w_f3 == F3_SLL && w_f7 != F7_ADD) ||
                    (w_f3 == F3_SRL_SRA && w_f7 != F7_SRL && w_f7 != F7_SRA));
        o_dec.fmt         = FMT_I;
        // Shift-immediates carry their funct7 through to execute.
        o_dec.funct7      = (w_f3 == F3_SLL || w_f3 == F3_SRL_SRA) ? w_f7 : '0;
        o_dec.imm         = imm_i(i_instr);
        o_dec.reg_write   = 1'b1;
        o_dec.alu_src_imm = 1'b1;
      end
      OP_LOAD: begin
        w_legal = !(w_f3 == 3'b011 || w_f3[2:1] == 2'b11);
        o_dec.fmt         = FMT_I;
        o_dec.imm         = imm_i(i_instr);
        o_dec.reg_write   = 1'b1;
        o_dec.mem_read    = 1'b1;
        o_dec.alu_src_imm = 1'b1;
      end
      OP_STORE: begin
        w_legal = (w_f3 < 3'b011);
        o_dec.fmt         = FMT_S;
        o_dec.rd          = '0;
        o_dec.imm         = imm_s(i_instr);
        o_dec.mem_write   = 1'b1;
        o_dec.alu_src_imm = 1'b1;
      end
      OP_BRANCH: begin
        w_legal = (w_f3[2:1] != 2'b01);
        o_dec.fmt    = FMT_B;
        o_dec.rd     = '0;
        o_dec.imm    = imm_b(i_instr);
        o_dec.branch = 1'b1;
      end
      default: ;
    endcase
    if (!w_legal || i_instr[1:0] != 2'b11) begin
      o_dec.fmt         = FMT_ILL;
      o_dec.rd          = i_instr[11:7];
      o_dec.funct7      = '0;
      o_dec.imm         = '0;
      o_dec.reg_write   = 1'b0;
      o_dec.mem_read    = 1'b0;
      o_dec.mem_write   = 1'b0;
      o_dec.branch      = 1'b0;
      o_dec.alu_src_imm = 1'b0;
      o_dec.illegal     = 1'b1;
    end
  end

endmodule

// File: rtl/riscv_decode_stage.sv
// Decode pipeline stage: single-entry valid/ready register around the decoder.
module riscv_decode_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ADDR = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_fmt,
  output logic [ADDR-1:0] out_rd,
  output logic [ADDR-1:0] out_rs1,
  output logic [ADDR-1:0] out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_branch,
  output logic            out_alu_src_imm,
  output logic            out_illegal
);
  import riscv_pkg::*;

  decoded_instr_t w_dec;
  decoded_instr_t r_out;
  logic           r_valid;
  logic           w_accept;

  riscv_instr_decoder u_decoder (
    .i_instr (in_instr),
    .i_pc    (in_pc),
    .o_dec   (w_dec)
  );

  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // Flush drops both the held entry and anything offered this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_out   <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_out   <= w_dec;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid       = r_valid;
  assign out_pc          = r_out.pc;
  assign out_opcode      = r_out.opcode;
  assign out_fmt         = r_out.fmt;
  assign out_rd          = r_out.rd;
  assign out_rs1         = r_out.rs1;
  assign out_rs2         = r_out.rs2;
  assign out_funct3      = r_out.funct3;
  assign out_funct7      = r_out.funct7;
  assign out_imm         = r_out.imm;
  assign out_reg_write   = r_out.reg_write;
  assign out_mem_read    = r_out.mem_read;
  assign out_mem_write   = r_out.mem_write;
  assign out_branch      = r_out.branch;
  assign out_alu_src_imm = r_out.alu_src_imm;
  assign out_illegal     = r_out.illegal;

endmodule
